// File: rtl/axi_lite_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi_lite_uart_tx                                              |
// | Brief    : AXI4-Lite (64-bit) console UART transmitter. Software writes  |
// |            bytes into a TX FIFO. The bytes are serialised 8N1 (or 8E1)   |
// |            at a programmable divisor. Status and divisor registers are   |
// |            readable.                                                     |
// | Options  : UART_TX_PARITY_EN - insert an even-parity bit before stop     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module axi_lite_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RST    = 16'd867
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic [31:0] UART_AWADDR,
   input  logic        UART_AWVALID,
   output logic        UART_AWREADY,
   input  logic [63:0] UART_WDATA,
   input  logic [7:0]  UART_WSTRB,
   input  logic        UART_WVALID,
   output logic        UART_WREADY,
   output logic [1:0]  UART_BRESP,
   output logic        UART_BVALID,
   input  logic        UART_BREADY,
   input  logic [31:0] UART_ARADDR,
   input  logic        UART_ARVALID,
   output logic        UART_ARREADY,
   output logic [63:0] UART_RDATA,
   output logic [1:0]  UART_RRESP,
   output logic        UART_RVALID,
   input  logic        UART_RREADY,
   output logic        UART_TXD,
   output logic        TX_EMPTY
);

   localparam int unsigned c_IDX_W      = $clog2(FIFO_DEPTH);
   localparam int unsigned c_PTR_W      = c_IDX_W + 1;
   localparam logic [1:0]  c_OFF_TXDATA = 2'd0;
   localparam logic [1:0]  c_OFF_STATUS = 2'd1;
   localparam logic [1:0]  c_OFF_DIV    = 2'd2;
   localparam logic [1:0]  c_RESP_OKAY  = 2'b00;
   localparam logic [1:0]  c_RESP_SLV   = 2'b10;
`ifdef UART_TX_PARITY_EN
   localparam logic        c_PARITY_ON  = 1'b1;
`else
   localparam logic        c_PARITY_ON  = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } tx_state_t;

   // Bus-side registers
   logic               r_awready, r_bvalid, r_arready, r_rvalid;
   logic [1:0]         r_bresp, r_rresp;
   logic [63:0]        r_rdata;
   logic [15:0]        r_div;

   // FIFO storage and pointers (extra MSB distinguishes full from empty)
   logic [7:0]         r_fifo_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wptr, r_rptr;
   logic [c_PTR_W-1:0] w_count;
   logic [31:0]        w_count32;
   logic [3:0]         w_count_sat;
   logic               w_fifo_empty, w_fifo_full;
   logic [7:0]         w_fifo_head;
   logic               w_push_req, w_push, w_pop;

   // Transmitter
   tx_state_t          r_state, w_state_nxt;
   logic [15:0]        r_baud_cnt, w_baud_nxt;
   logic [15:0]        r_div_lat, w_div_lat_nxt;
   logic [7:0]         r_shift, w_shift_nxt;
   logic [2:0]         r_bit_idx, w_bit_nxt;
   logic               r_txd, w_txd_nxt;
   logic               r_parity, w_parity_nxt;
   logic               w_bit_end, w_load;

   // Decode
   logic               w_wr_hs, w_wr_in_win, w_rd_hs, w_rd_in_win;
   logic [1:0]         w_wr_off, w_rd_off;
   logic [1:0]         w_wr_resp, w_rd_resp;
   logic [63:0]        w_rd_data, w_status;
   logic               w_unused_bits;

   assign w_unused_bits = ^{UART_AWADDR[2:0], UART_ARADDR[2:0], UART_WDATA[63:16], UART_WSTRB[7:2]};

   assign w_wr_hs     = r_awready & UART_AWVALID & UART_WVALID;
   assign w_wr_in_win = (UART_AWADDR[31:5] == BASE_ADDR[31:5]);
   assign w_wr_off    = UART_AWADDR[4:3];
   assign w_rd_hs     = r_arready & UART_ARVALID;
   assign w_rd_in_win = (UART_ARADDR[31:5] == BASE_ADDR[31:5]);
   assign w_rd_off    = UART_ARADDR[4:3];

   assign w_count      = r_wptr - r_rptr;
   assign w_count32    = 32'(w_count);
   assign w_count_sat  = (w_count32 > 32'd15) ? 4'hF : w_count32[3:0];
   assign w_fifo_empty = (r_wptr == r_rptr);
   assign w_fifo_full  = (r_wptr[c_IDX_W] != r_rptr[c_IDX_W]) &&
                         (r_wptr[c_IDX_W-1:0] == r_rptr[c_IDX_W-1:0]);
   assign w_fifo_head  = r_fifo_mem[r_rptr[c_IDX_W-1:0]];

   // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds
   assign w_push_req = w_wr_hs & w_wr_in_win & (w_wr_off == c_OFF_TXDATA) & UART_WSTRB[0];
   assign w_push     = w_push_req & (~w_fifo_full | w_pop);

   assign w_status = {56'd0, w_count_sat, c_PARITY_ON, (r_state != S_IDLE), w_fifo_empty, w_fifo_full};

   // Write response: decode errors and dropped bytes report SLVERR
   always_comb begin
      w_wr_resp = c_RESP_OKAY;
      if (!w_wr_in_win) begin
         w_wr_resp = c_RESP_SLV;
      end else begin
         case (w_wr_off)
            c_OFF_TXDATA: if (w_push_req && !w_push) w_wr_resp = c_RESP_SLV;
            c_OFF_STATUS: w_wr_resp = c_RESP_OKAY;
            c_OFF_DIV:    w_wr_resp = c_RESP_OKAY;
            default:      w_wr_resp = c_RESP_SLV;
         endcase
      end
   end

   // Read data mux
   always_comb begin
      w_rd_data = 64'd0;
      w_rd_resp = c_RESP_OKAY;
      if (!w_rd_in_win) begin
         w_rd_resp = c_RESP_SLV;
      end else begin
         case (w_rd_off)
            c_OFF_TXDATA: w_rd_data = 64'd0;
            c_OFF_STATUS: w_rd_data = w_status;
            c_OFF_DIV:    w_rd_data = {48'd0, r_div};
            default:      w_rd_resp = c_RESP_SLV;
         endcase
      end
   end

   // Write channel: AW/W accepted together; ready pre-asserts when the B slot frees up
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
      end else begin
         r_awready <= UART_AWVALID & UART_WVALID & ~r_awready & (~r_bvalid | UART_BREADY);
         if (w_wr_hs) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_resp;
         end else if (r_bvalid && UART_BREADY) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Divisor register with byte-lane merge
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_div <= DIV_RST;
      end else if (w_wr_hs && w_wr_in_win && (w_wr_off == c_OFF_DIV)) begin
         if (UART_WSTRB[0]) r_div[7:0]  <= UART_WDATA[7:0];
         if (UART_WSTRB[1]) r_div[15:8] <= UART_WDATA[15:8];
      end
   end

   // Read channel: one outstanding read, response held until RREADY
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rresp   <= 2'b00;
         r_rdata   <= 64'd0;
      end else begin
         r_arready <= UART_ARVALID & ~r_arready & (~r_rvalid | UART_RREADY);
         if (w_rd_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_resp;
            r_rdata  <= w_rd_data;
         end else if (r_rvalid && UART_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity
   always_ff @(posedge CLK) begin
      if (w_push) r_fifo_mem[r_wptr[c_IDX_W-1:0]] <= UART_WDATA[7:0];
   end

   // FIFO pointers
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
      end
   end

   assign w_bit_end = (r_baud_cnt == r_div_lat);

   // Transmitter next-state: each bit lasts r_div_lat+1 cycles; a waiting byte loads straight out of STOP
   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = r_baud_cnt;
      w_div_lat_nxt = r_div_lat;
      w_shift_nxt   = r_shift;
      w_bit_nxt     = r_bit_idx;
      w_txd_nxt     = r_txd;
      w_parity_nxt  = r_parity;
      w_load        = 1'b0;
      w_pop         = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_txd_nxt = 1'b1;
            if (!w_fifo_empty) w_load = 1'b1;
         end
         S_START: begin
            if (w_bit_end) begin
               w_baud_nxt  = 16'd0;
               w_state_nxt = S_DATA;
               w_bit_nxt   = 3'd0;
               w_txd_nxt   = r_shift[0];
            end else begin
               w_baud_nxt = r_baud_cnt + 16'd1;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_baud_nxt = 16'd0;
               if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
                  w_txd_nxt   = r_parity;
`else
                  w_state_nxt = S_STOP;
                  w_txd_nxt   = 1'b1;
`endif
               end else begin
                  w_bit_nxt   = r_bit_idx + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
                  w_txd_nxt   = r_shift[1];
               end
            end else begin
               w_baud_nxt = r_baud_cnt + 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_bit_end) begin
               w_baud_nxt  = 16'd0;
               w_state_nxt = S_STOP;
               w_txd_nxt   = 1'b1;
            end else begin
               w_baud_nxt = r_baud_cnt + 16'd1;
            end
         end
`endif
         S_STOP: begin
            if (w_bit_end) begin
               w_baud_nxt = 16'd0;
               if (!w_fifo_empty) w_load = 1'b1;
               else               w_state_nxt = S_IDLE;
            end else begin
               w_baud_nxt = r_baud_cnt + 16'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
         end
      endcase
      if (w_load) begin
         w_pop         = 1'b1;
         w_state_nxt   = S_START;
         w_txd_nxt     = 1'b0;
         w_baud_nxt    = 16'd0;
         w_div_lat_nxt = r_div;
         w_shift_nxt   = w_fifo_head;
         w_bit_nxt     = 3'd0;
         w_parity_nxt  = ^w_fifo_head;
      end
   end

   // Transmitter state register; TXD is registered so it never glitches
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= 16'd0;
         r_div_lat  <= DIV_RST;
         r_shift    <= 8'd0;
         r_bit_idx  <= 3'd0;
         r_txd      <= 1'b1;
         r_parity   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud_cnt <= w_baud_nxt;
         r_div_lat  <= w_div_lat_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_idx  <= w_bit_nxt;
         r_txd      <= w_txd_nxt;
         r_parity   <= w_parity_nxt;
      end
   end

   assign UART_AWREADY = r_awready;
   assign UART_WREADY  = r_awready;
   assign UART_BVALID  = r_bvalid;
   assign UART_BRESP   = r_bresp;
   assign UART_ARREADY = r_arready;
   assign UART_RVALID  = r_rvalid;
   assign UART_RRESP   = r_rresp;
   assign UART_RDATA   = r_rdata;
   assign UART_TXD     = r_txd;
   assign TX_EMPTY     = w_fifo_empty & (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axi_lite_uart_tx                                           |
// | Brief    : Directed self-checking bench for axi_lite_uart_tx. Honours    |
// |            UART_TX_PARITY_EN when defined for the build.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_axi_lite_uart_tx;

   localparam logic [31:0] c_BASE = 32'h2000_0000;
`ifdef UART_TX_PARITY_EN
   localparam int          c_NBITS      = 11;
   localparam logic [63:0] c_STATUS_RST = 64'h0A;
   localparam logic [63:0] c_STATUS_FUL = 64'h8D;
`else
   localparam int          c_NBITS      = 10;
   localparam logic [63:0] c_STATUS_RST = 64'h02;
   localparam logic [63:0] c_STATUS_FUL = 64'h85;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [63:0] wdata = '0;
   logic [7:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;
   logic        txd;
   logic        tx_empty;

   int          compared = 0;
   int          mismatched = 0;
   logic [7:0]  exp_bytes [16];
   int          exp_div [16];

   axi_lite_uart_tx #(
      .BASE_ADDR (c_BASE),
      .FIFO_DEPTH(8),
      .DIV_RST   (16'd867)
   ) dut (
      .CLK         (clk),
      .RSTn        (rst_n),
      .UART_AWADDR (awaddr),
      .UART_AWVALID(awvalid),
      .UART_AWREADY(awready),
      .UART_WDATA  (wdata),
      .UART_WSTRB  (wstrb),
      .UART_WVALID (wvalid),
      .UART_WREADY (wready),
      .UART_BRESP  (bresp),
      .UART_BVALID (bvalid),
      .UART_BREADY (bready),
      .UART_ARADDR (araddr),
      .UART_ARVALID(arvalid),
      .UART_ARREADY(arready),
      .UART_RDATA  (rdata),
      .UART_RRESP  (rresp),
      .UART_RVALID (rvalid),
      .UART_RREADY (rready),
      .UART_TXD    (txd),
      .TX_EMPTY    (tx_empty)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            output logic [1:0] resp);
      int n;
      resp    = 2'b11;
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b1;
      n = 0;
      @(negedge clk);
      while (!awready && n < 50) begin @(negedge clk); n++; end
      if (!awready) begin
         compared++; mismatched++;
         $display("FAIL write_aw_timeout addr=%h awready=%b required 1", a, awready);
         awvalid = 1'b0; wvalid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      if (!bvalid) begin
         compared++; mismatched++;
         $display("FAIL write_b_timeout addr=%h bvalid=%b required 1", a, bvalid);
         return;
      end
      resp = bresp;
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp);
      int n;
      d       = '1;
      resp    = 2'b11;
      araddr  = a;
      arvalid = 1'b1;
      rready  = 1'b1;
      n = 0;
      @(negedge clk);
      while (!arready && n < 50) begin @(negedge clk); n++; end
      if (!arready) begin
         compared++; mismatched++;
         $display("FAIL read_ar_timeout addr=%h arready=%b required 1", a, arready);
         arvalid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rvalid && n < 50) begin @(negedge clk); n++; end
      if (!rvalid) begin
         compared++; mismatched++;
         $display("FAIL read_r_timeout addr=%h rvalid=%b required 1", a, rvalid);
         return;
      end
      d    = rdata;
      resp = rresp;
      @(posedge clk); #1;
   endtask

   // Waits for a start bit, then checks every cycle of nbytes contiguous frames
   task automatic check_stream(input int nbytes, input string name);
      int n;
      bit first;
      n = 0;
      @(negedge clk);
      while (txd !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
      if (txd !== 1'b0) begin
         compared++; mismatched++;
         $display("FAIL %s_start txd=%b required 0", name, txd);
         return;
      end
      first = 1'b1;
      for (int f = 0; f < nbytes; f++) begin
         logic [c_NBITS-1:0] frame;
         int bad_bit;
         logic got;
`ifdef UART_TX_PARITY_EN
         frame = {1'b1, ^exp_bytes[f], exp_bytes[f], 1'b0};
`else
         frame = {1'b1, exp_bytes[f], 1'b0};
`endif
         bad_bit = -1;
         got = 1'b0;
         for (int b = 0; b < c_NBITS; b++) begin
            for (int c = 0; c <= exp_div[f]; c++) begin
               if (!first) @(negedge clk);
               first = 1'b0;
               if (txd !== frame[b] && bad_bit < 0) begin
                  bad_bit = b;
                  got = txd;
               end
            end
         end
         compared++;
         if (bad_bit >= 0) begin
            mismatched++;
            $display("FAIL %s_frame%0d byte=%h bit%0d txd=%b required %b",
                     name, f, exp_bytes[f], bad_bit, got, frame[bad_bit]);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      compared++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, txd, tx_empty} !== 11'b000_00_00_00_11) begin
         mismatched++;
         $display("FAIL reset_outputs got=%b required 00000000011",
                  {awready, wready, arready, bvalid, rvalid, bresp, rresp, txd, tx_empty});
      end
      compared++;
      if (rdata !== 64'd0) begin
         mismatched++;
         $display("FAIL reset_rdata got=%h required 0", rdata);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      compared++;
      if ({txd, tx_empty} !== 2'b11) begin
         mismatched++;
         $display("FAIL post_reset_idle got=%b required 11", {txd, tx_empty});
      end
   endtask

   task automatic test_decode();
      logic [63:0] d;
      logic [1:0]  r;
      axi_read(c_BASE + 32'h08, d, r);
      compared++;
      if ({r, d} !== {2'b00, c_STATUS_RST}) begin
         mismatched++;
         $display("FAIL status_reset got=%b/%h required 00/%h", r, d, c_STATUS_RST);
      end
      axi_read(c_BASE + 32'h10, d, r);
      compared++;
      if ({r, d} !== {2'b00, 64'd867}) begin
         mismatched++;
         $display("FAIL div_reset got=%b/%h required 00/363", r, d);
      end
      axi_read(c_BASE + 32'h18, d, r);
      compared++;
      if ({r, d} !== {2'b10, 64'd0}) begin
         mismatched++;
         $display("FAIL read_0x18 got=%b/%h required 10/0", r, d);
      end
      axi_read(c_BASE + 32'h04, d, r);
      compared++;
      if ({r, d} !== {2'b00, 64'd0}) begin
         mismatched++;
         $display("FAIL read_txdata got=%b/%h required 00/0", r, d);
      end
      axi_read(c_BASE + 32'h28, d, r);
      compared++;
      if ({r, d} !== {2'b10, 64'd0}) begin
         mismatched++;
         $display("FAIL read_outside got=%b/%h required 10/0", r, d);
      end
      axi_write(c_BASE + 32'h40, 64'h41, 8'hFF, r);
      compared++;
      if (r !== 2'b10) begin
         mismatched++;
         $display("FAIL write_outside bresp=%b required 10", r);
      end
      axi_write(c_BASE + 32'h18, 64'h41, 8'hFF, r);
      compared++;
      if (r !== 2'b10) begin
         mismatched++;
         $display("FAIL write_0x18 bresp=%b required 10", r);
      end
      axi_write(c_BASE + 32'h08, 64'hFF, 8'hFF, r);
      compared++;
      if (r !== 2'b00) begin
         mismatched++;
         $display("FAIL write_status bresp=%b required 00", r);
      end
      axi_write(c_BASE, 64'h4100, 8'h02, r);
      compared++;
      if (r !== 2'b00) begin
         mismatched++;
         $display("FAIL write_txdata_nostrb bresp=%b required 00", r);
      end
      axi_read(c_BASE + 32'h08, d, r);
      compared++;
      if ({r, d, txd} !== {2'b00, c_STATUS_RST, 1'b1}) begin
         mismatched++;
         $display("FAIL status_after_ignored got=%b/%h txd=%b required 00/%h txd=1", r, d, txd, c_STATUS_RST);
      end
   endtask

   task automatic test_div_merge();
      logic [63:0] d;
      logic [1:0]  r;
      axi_write(c_BASE + 32'h10, 64'hFFFF_FFFF_FFFF_0500, 8'h02, r);
      axi_read(c_BASE + 32'h10, d, r);
      compared++;
      if ({r, d} !== {2'b00, 64'h0563}) begin
         mismatched++;
         $display("FAIL div_merge_hi got=%b/%h required 00/563", r, d);
      end
      axi_write(c_BASE + 32'h10, 64'h0000_0000_0000_77AB, 8'h01, r);
      axi_read(c_BASE + 32'h10, d, r);
      compared++;
      if ({r, d} !== {2'b00, 64'h05AB}) begin
         mismatched++;
         $display("FAIL div_merge_lo got=%b/%h required 00/5ab", r, d);
      end
   endtask

   task automatic test_basic_frame();
      logic [1:0] r;
      axi_write(c_BASE + 32'h10, 64'd3, 8'h03, r);
      exp_bytes[0] = 8'h55;
      exp_div[0]   = 3;
      fork
         begin
            logic [1:0] r2;
            axi_write(c_BASE, 64'h55, 8'h01, r2);
            compared++;
            if (r2 !== 2'b00) begin
               mismatched++;
               $display("FAIL basic_bresp got=%b required 00", r2);
            end
         end
         check_stream(1, "basic");
      join
      @(negedge clk);
      compared++;
      if ({tx_empty, txd} !== 2'b11) begin
         mismatched++;
         $display("FAIL basic_tx_empty got=%b required 11", {tx_empty, txd});
      end
   endtask

   task automatic test_div_change();
      logic [1:0] r;
      axi_write(c_BASE + 32'h10, 64'd3, 8'h03, r);
      exp_bytes[0] = 8'hC3; exp_div[0] = 3;
      exp_bytes[1] = 8'h3C; exp_div[1] = 1;
      fork
         begin
            logic [1:0] r2;
            axi_write(c_BASE, 64'hC3, 8'h01, r2);
            repeat (8) @(negedge clk);
            axi_write(c_BASE + 32'h10, 64'd1, 8'h03, r2);
            axi_write(c_BASE, 64'h3C, 8'h01, r2);
            compared++;
            if (r2 !== 2'b00) begin
               mismatched++;
               $display("FAIL divchg_bresp got=%b required 00", r2);
            end
         end
         check_stream(2, "divchg");
      join
   endtask

   task automatic test_back_to_back();
      logic [1:0] r;
      axi_write(c_BASE + 32'h10, 64'd100, 8'h03, r);
      for (int i = 0; i < 9; i++) begin
         exp_bytes[i] = 8'h30 + 8'(i);
         exp_div[i]   = 100;
      end
      fork
         begin
            logic [1:0]  r2;
            logic [63:0] d;
            for (int i = 0; i < 10; i++) begin
               axi_write(c_BASE, 64'(8'h30 + 8'(i)), 8'h01, r2);
               compared++;
               if (r2 !== ((i < 9) ? 2'b00 : 2'b10)) begin
                  mismatched++;
                  $display("FAIL b2b_bresp%0d got=%b required %b", i, r2, (i < 9) ? 2'b00 : 2'b10);
               end
            end
            axi_read(c_BASE + 32'h08, d, r2);
            compared++;
            if ({r2, d} !== {2'b00, c_STATUS_FUL}) begin
               mismatched++;
               $display("FAIL b2b_status got=%b/%h required 00/%h", r2, d, c_STATUS_FUL);
            end
         end
         check_stream(9, "b2b");
      join
      @(negedge clk);
      compared++;
      if (tx_empty !== 1'b1) begin
         mismatched++;
         $display("FAIL b2b_tx_empty got=%b required 1", tx_empty);
      end
   endtask

   task automatic test_bready_hold();
      logic [63:0] d;
      logic [1:0]  r;
      int n;
      int bad;
      @(negedge clk);
      awaddr = c_BASE + 32'h10; wdata = 64'd7; wstrb = 8'h03;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!awready && n < 50) begin @(negedge clk); n++; end
      compared++;
      if (!awready) begin
         mismatched++;
         $display("FAIL hold_first_accept awready=%b required 1", awready);
      end
      @(posedge clk); #1;
      wdata = 64'd9;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if ({bvalid, awready} !== 2'b10) bad++;
      end
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("FAIL hold_bvalid_held bad_cycles=%0d required 0 (bvalid,awready)=%b required 10", bad, {bvalid, awready});
      end
      bready = 1'b1;
      @(negedge clk);
      compared++;
      if ({bvalid, awready} !== 2'b01) begin
         mismatched++;
         $display("FAIL hold_second_accept (bvalid,awready)=%b required 01", {bvalid, awready});
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      compared++;
      if ({bvalid, bresp} !== 3'b100) begin
         mismatched++;
         $display("FAIL hold_second_bresp (bvalid,bresp)=%b required 100", {bvalid, bresp});
      end
      @(posedge clk); #1;
      axi_read(c_BASE + 32'h10, d, r);
      compared++;
      if ({r, d} !== {2'b00, 64'd9}) begin
         mismatched++;
         $display("FAIL hold_div_value got=%b/%h required 00/9", r, d);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [1:0] r;
      axi_write(c_BASE + 32'h10, 64'd1, 8'h03, r);
      exp_bytes[0] = 8'h07; exp_div[0] = 1;
      exp_bytes[1] = 8'h03; exp_div[1] = 1;
      fork
         begin
            logic [1:0] r2;
            axi_write(c_BASE, 64'h07, 8'h01, r2);
            axi_write(c_BASE, 64'h03, 8'h01, r2);
         end
         check_stream(2, "parity");
      join
   endtask
`endif

   task automatic test_reset_midframe();
      logic [63:0] d;
      logic [1:0]  r;
      int n;
      int bad;
      axi_write(c_BASE + 32'h10, 64'd3, 8'h03, r);
      axi_write(c_BASE, 64'hA5, 8'h01, r);
      axi_write(c_BASE, 64'h11, 8'h01, r);
      axi_write(c_BASE, 64'h22, 8'h01, r);
      n = 0;
      while (txd !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      compared++;
      if ({txd, tx_empty, bvalid, rvalid} !== 4'b1100) begin
         mismatched++;
         $display("FAIL midframe_reset (txd,tx_empty,bvalid,rvalid)=%b required 1100", {txd, tx_empty, bvalid, rvalid});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      axi_read(c_BASE + 32'h08, d, r);
      compared++;
      if ({r, d} !== {2'b00, c_STATUS_RST}) begin
         mismatched++;
         $display("FAIL midframe_status got=%b/%h required 00/%h", r, d, c_STATUS_RST);
      end
      axi_read(c_BASE + 32'h10, d, r);
      compared++;
      if (d !== 64'd867) begin
         mismatched++;
         $display("FAIL midframe_div got=%h required 363", d);
      end
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) bad++;
      end
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("FAIL midframe_txd_idle low_cycles=%0d required 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_div_merge();
      test_basic_frame();
      test_div_change();
      test_back_to_back();
      test_bready_hold();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
